// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and ALU op codes.
package cpu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned ALU_OP_W   = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND     = 3'b000,
    ALU_OR      = 3'b001,
    ALU_ADD     = 3'b010,
    ALU_SUB     = 3'b011,
    ALU_LT      = 3'b100,
    ALU_GE      = 3'b101,
    ALU_EQ      = 3'b110,
    ALU_ILLEGAL = 3'b111
  } alu_op_e;

  // Logical ops take a zero-extended immediate; everything else sign-extends.
  function automatic logic imm_zero_ext(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_AND) || (op == ALU_OR);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Combinational operand select: youngest matching result wins, r0 never forwarded.
module fwd_mux #(
  parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic                  fwd1_valid,
  input  logic                  fwd1_reg_write,
  input  logic [REG_ADDR_W-1:0] fwd1_rd,
  input  logic [DATA_W-1:0]     fwd1_data,
  input  logic                  fwd2_valid,
  input  logic                  fwd2_reg_write,
  input  logic [REG_ADDR_W-1:0] fwd2_rd,
  input  logic [DATA_W-1:0]     fwd2_data,
  output logic [DATA_W-1:0]     data_c
);

  logic addr_nz_c;
  logic hit1_c;
  logic hit2_c;

  // Match detection and priority select (fwd1, then fwd2, then register file).
  always_comb begin
    addr_nz_c = (addr != '0);
    hit1_c    = fwd1_valid && fwd1_reg_write && (fwd1_rd == addr) && addr_nz_c;
    hit2_c    = fwd2_valid && fwd2_reg_write && (fwd2_rd == addr) && addr_nz_c;
    data_c    = rf_data;
    if (hit1_c) begin
      data_c = fwd1_data;
    end else if (hit2_c) begin
      data_c = fwd2_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute stage: forwarding, immediate select, load-use stall, flush.
module alu_issue_stage #(
  parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int unsigned IMM_W      = cpu_pkg::IMM_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [IMM_W-1:0]      id_imm,
  input  logic                  id_alu_src,
  input  logic [2:0]            id_alu_control,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  fwd1_valid,
  input  logic                  fwd1_reg_write,
  input  logic [REG_ADDR_W-1:0] fwd1_rd,
  input  logic [DATA_W-1:0]     fwd1_data,
  input  logic                  fwd2_valid,
  input  logic                  fwd2_reg_write,
  input  logic [REG_ADDR_W-1:0] fwd2_rd,
  input  logic [DATA_W-1:0]     fwd2_data,
  input  logic                  ex_ready,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_a,
  output logic [DATA_W-1:0]     ex_b,
  output logic [2:0]            ex_alu_control,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  illegal_op
);

  import cpu_pkg::*;

  logic              hazard_c;
  logic              is_illegal_c;
  logic [DATA_W-1:0] rs_fwd_c;
  logic [DATA_W-1:0] rt_fwd_c;
  logic [DATA_W-1:0] imm_ext_c;
  logic [DATA_W-1:0] b_sel_c;

  fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .addr           (id_rs_addr),
    .rf_data        (id_rs_data),
    .fwd1_valid     (fwd1_valid),
    .fwd1_reg_write (fwd1_reg_write),
    .fwd1_rd        (fwd1_rd),
    .fwd1_data      (fwd1_data),
    .fwd2_valid     (fwd2_valid),
    .fwd2_reg_write (fwd2_reg_write),
    .fwd2_rd        (fwd2_rd),
    .fwd2_data      (fwd2_data),
    .data_c         (rs_fwd_c)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .addr           (id_rt_addr),
    .rf_data        (id_rt_data),
    .fwd1_valid     (fwd1_valid),
    .fwd1_reg_write (fwd1_reg_write),
    .fwd1_rd        (fwd1_rd),
    .fwd1_data      (fwd1_data),
    .fwd2_valid     (fwd2_valid),
    .fwd2_reg_write (fwd2_reg_write),
    .fwd2_rd        (fwd2_rd),
    .fwd2_data      (fwd2_data),
    .data_c         (rt_fwd_c)
  );

  // Load-use detection, handshake and operand-b selection.
  always_comb begin
    hazard_c = ex_valid && ex_mem_read && ex_reg_write && (ex_rd_addr != '0) &&
               ((ex_rd_addr == id_rs_addr) ||
                ((ex_rd_addr == id_rt_addr) && !id_alu_src));
    id_ready     = ex_ready && !hazard_c && !reset;
    is_illegal_c = (id_alu_control == ALU_ILLEGAL);
    if (imm_zero_ext(id_alu_control)) begin
      imm_ext_c = DATA_W'(id_imm);
    end else begin
      imm_ext_c = DATA_W'($signed(id_imm));
    end
    b_sel_c = id_alu_src ? imm_ext_c : rt_fwd_c;
  end

  // EX register: flush beats back-pressure beats stall beats capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid       <= 1'b0;
      ex_a           <= '0;
      ex_b           <= '0;
      ex_alu_control <= 3'b000;
      ex_rd_addr     <= '0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      illegal_op     <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      illegal_op   <= 1'b0;
    end else if (!ex_ready) begin
      illegal_op <= 1'b0;
    end else if (hazard_c && id_valid) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      illegal_op   <= 1'b0;
    end else if (id_valid) begin
      ex_valid   <= 1'b1;
      ex_a       <= rs_fwd_c;
      ex_b       <= b_sel_c;
      ex_rd_addr <= id_rd_addr;
      if (is_illegal_c) begin
        ex_alu_control <= ALU_ADD;
        ex_reg_write   <= 1'b0;
        ex_mem_read    <= 1'b0;
        illegal_op     <= 1'b1;
      end else begin
        ex_alu_control <= id_alu_control;
        ex_reg_write   <= id_reg_write;
        ex_mem_read    <= id_mem_read;
        illegal_op     <= 1'b0;
      end
    end else begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      illegal_op   <= 1'b0;
    end
  end

endmodule
